// File: rtl/apb_gpio_pkg.sv
// Shared constants, state encoding and offset-decode helpers for the APB GPIO completer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package apb_gpio_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int OFS_W  = 4;
    localparam int CNT_W  = 4;

    localparam logic [OFS_W-1:0] OFS_OUT      = 4'h0;
    localparam logic [OFS_W-1:0] OFS_DIR      = 4'h1;
    localparam logic [OFS_W-1:0] OFS_IN       = 4'h2;
    localparam logic [OFS_W-1:0] OFS_ID       = 4'h3;
    localparam logic [OFS_W-1:0] OFS_IRQ_EN   = 4'h4;
    localparam logic [OFS_W-1:0] OFS_IRQ_STAT = 4'h5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic logic ofs_readable(input logic [OFS_W-1:0] ofs, input logic irq_present);
        return (ofs <= OFS_ID) ||
               (irq_present && ((ofs == OFS_IRQ_EN) || (ofs == OFS_IRQ_STAT)));
    endfunction

    function automatic logic ofs_writable(input logic [OFS_W-1:0] ofs, input logic irq_present);
        return (ofs == OFS_OUT) || (ofs == OFS_DIR) ||
               (irq_present && ((ofs == OFS_IRQ_EN) || (ofs == OFS_IRQ_STAT)));
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for GPIO pins with optional previous-value flop and rising-edge vector.
// Latency: 2 PCLK cycles from a settled pin change to sync_out; rise is combinational on sync_out.
// Backpressure: none, free-running.
module gpio_sync #(
    parameter int W       = 8,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

    generate
        if (EDGE_EN) begin : g_edge
            logic [W-1:0] prev_q;

            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    prev_q <= '0;
                end else begin
                    prev_q <= sync_q;
                end
            end

            assign rise = sync_q & ~prev_q;
        end else begin : g_no_edge
            assign rise = '0;
        end
    endgenerate

endmodule

// File: rtl/apb_gpio_slave.sv
// APB completer hosting GPIO OUT/DIR/IN/ID registers; GPIO_IRQ_EN adds IRQ_EN/IRQ_STAT and irq.
// Latency: WAIT_STATES PREADY-low access cycles, completion on access cycle WAIT_STATES+1.
// Backpressure: PREADY held low while the wait counter runs; PSEL drop aborts silently.
module apb_gpio_slave
    import apb_gpio_pkg::*;
#(
    parameter int         WAIT_STATES = 1,
    parameter logic [7:0] ID_VALUE    = 8'hA5
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [DATA_W-1:0] gpio_in,
    output logic [DATA_W-1:0] gpio_out,
    output logic [DATA_W-1:0] gpio_oe,
    output logic              irq
);

`ifdef GPIO_IRQ_EN
    localparam logic IRQ_PRESENT = 1'b1;
`else
    localparam logic IRQ_PRESENT = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OFS_W-1:0]   addr_q;
    logic               write_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  out_q;
    logic [DATA_W-1:0]  dir_q;
    logic [DATA_W-1:0]  sync_in;
    logic [DATA_W-1:0]  sync_rise;
    logic               done;
    logic               rd_ok;
    logic               wr_ok;
    logic               commit;
    logic [DATA_W-1:0]  rd_mux;

`ifdef GPIO_IRQ_EN
    logic [DATA_W-1:0]  irq_en_q;
    logic [DATA_W-1:0]  irq_stat_q;
    logic [DATA_W-1:0]  irq_clr;
    logic               irq_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // PENABLE without a preceding setup phase is ignored
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && PSEL && !PENABLE) begin
                addr_q  <= PADDR[OFS_W-1:0];
                write_q <= PWRITE;
                wdata_q <= PWDATA;
            end
        end
    end

    // Response is decoded purely from flops so no bus input reaches PREADY/PRDATA/PSLVERR
    assign done   = (state_q == ACCESS) && (cnt_q == '0);
    assign rd_ok  = ofs_readable(addr_q, IRQ_PRESENT);
    assign wr_ok  = ofs_writable(addr_q, IRQ_PRESENT);
    assign commit = done && PSEL && write_q && wr_ok;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            out_q <= '0;
            dir_q <= '0;
        end else if (commit) begin
            if (addr_q == OFS_OUT) out_q <= wdata_q;
            if (addr_q == OFS_DIR) dir_q <= wdata_q;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr_q)
            OFS_OUT:      rd_mux = out_q;
            OFS_DIR:      rd_mux = dir_q;
            OFS_IN:       rd_mux = sync_in;
            OFS_ID:       rd_mux = ID_VALUE;
`ifdef GPIO_IRQ_EN
            OFS_IRQ_EN:   rd_mux = irq_en_q;
            OFS_IRQ_STAT: rd_mux = irq_stat_q;
`endif
            default:      rd_mux = '0;
        endcase
    end

    assign PREADY   = done;
    assign PRDATA   = (done && !write_q && rd_ok) ? rd_mux : '0;
    assign PSLVERR  = done && (write_q ? !wr_ok : !rd_ok);
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

    gpio_sync #(
        .W       (DATA_W),
        .EDGE_EN (IRQ_PRESENT)
    ) u_sync (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .async_in (gpio_in),
        .sync_out (sync_in),
        .rise     (sync_rise)
    );

`ifdef GPIO_IRQ_EN
    // A clear and a fresh edge on the same bit resolve in favour of the edge
    assign irq_clr = (commit && addr_q == OFS_IRQ_STAT) ? wdata_q : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (commit && addr_q == OFS_IRQ_EN) irq_en_q <= wdata_q;
            irq_stat_q <= (irq_stat_q & ~irq_clr) | sync_rise;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    assign irq = irq_q;

    logic unused_paddr;
    assign unused_paddr = ^PADDR[ADDR_W-1:OFS_W];
`else
    assign irq = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{PADDR[ADDR_W-1:OFS_W], sync_rise};
`endif

endmodule
